// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - UI state/todo encodings and button rectangles shared with the renderer
package ui_pkg;

  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8
  } ui_state_e;

  typedef enum logic [1:0] {
    TODO_NONE       = 2'd0,
    TODO_FIND_KEY   = 2'd1,
    TODO_FIND_LIGHT = 2'd2,
    TODO_FIND_DOOR  = 2'd3
  } ui_todo_e;

  // Half-resolution (320x240) rectangles, [x0,x1) x [y0,y1)
  typedef struct packed {
    logic [8:0] x0;
    logic [8:0] x1;
    logic [8:0] y0;
    logic [8:0] y1;
  } ui_rect_t;

  localparam ui_rect_t RECT_S1    = '{x0: 9'd120, x1: 9'd200, y0: 9'd120, y1: 9'd140};
  localparam ui_rect_t RECT_S2    = '{x0: 9'd120, x1: 9'd200, y0: 9'd160, y1: 9'd180};
  localparam ui_rect_t RECT_S3    = '{x0: 9'd120, x1: 9'd200, y0: 9'd200, y1: 9'd220};
  localparam ui_rect_t RECT_STAFF = '{x0: 9'd240, x1: 9'd320, y0: 9'd220, y1: 9'd240};
  localparam ui_rect_t RECT_NEXT  = '{x0: 9'd120, x1: 9'd200, y0: 9'd160, y1: 9'd180};
  localparam ui_rect_t RECT_BACK  = '{x0: 9'd120, x1: 9'd200, y0: 9'd200, y1: 9'd220};
  localparam ui_rect_t RECT_RETRY = '{x0: 9'd120, x1: 9'd200, y0: 9'd160, y1: 9'd180};

  localparam int NUM_BTNS  = 7;
  localparam int BTN_S1    = 0;
  localparam int BTN_S2    = 1;
  localparam int BTN_S3    = 2;
  localparam int BTN_STAFF = 3;
  localparam int BTN_NEXT  = 4;
  localparam int BTN_BACK  = 5;
  localparam int BTN_RETRY = 6;

  function automatic logic in_rect(input logic [8:0] x, input logic [8:0] y, input ui_rect_t r);
    return (x >= r.x0) && (x < r.x1) && (y >= r.y0) && (y < r.y1);
  endfunction

endpackage

// File: rtl/ui_flow_ctrl_if.sv
// rtl/ui_flow_ctrl_if.sv - mouse/gameplay inputs and UI status bus of the flow controller
interface ui_flow_ctrl_if;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       mouse_click;
  logic       key_pulse;
  logic       door_pulse;
  logic       hit_pulse;
  logic [3:0] state;
  logic [1:0] key_find;
  logic [1:0] heart;
  logic [1:0] todo;
  logic [3:0] play_valid;

  modport master (
    output mouse_x, mouse_y, mouse_click, key_pulse, door_pulse, hit_pulse,
    input  state, key_find, heart, todo, play_valid
  );

  modport slave (
    input  mouse_x, mouse_y, mouse_click, key_pulse, door_pulse, hit_pulse,
    output state, key_find, heart, todo, play_valid
  );
endinterface

// File: rtl/ui_hit_test.sv
// rtl/ui_hit_test.sv - combinational pointer-vs-button hit test in half-res space
module ui_hit_test
  import ui_pkg::*;
(
  input  logic [8:0]          x,
  input  logic [8:0]          y,
  output logic [NUM_BTNS-1:0] btn_hit
);

  // Buttons sharing a rectangle all flag; the controller picks by state.
  assign btn_hit[BTN_S1]    = in_rect(x, y, RECT_S1);
  assign btn_hit[BTN_S2]    = in_rect(x, y, RECT_S2);
  assign btn_hit[BTN_S3]    = in_rect(x, y, RECT_S3);
  assign btn_hit[BTN_STAFF] = in_rect(x, y, RECT_STAFF);
  assign btn_hit[BTN_NEXT]  = in_rect(x, y, RECT_NEXT);
  assign btn_hit[BTN_BACK]  = in_rect(x, y, RECT_BACK);
  assign btn_hit[BTN_RETRY] = in_rect(x, y, RECT_RETRY);

endmodule

// File: rtl/ui_flow_ctrl.sv
// rtl/ui_flow_ctrl.sv - game-flow controller driving the UI status bus; STAGE_TIMER_EN adds a stage time limit
module ui_flow_ctrl
  import ui_pkg::*;
#(
  parameter logic [31:0] STAGE_TIME  = 32'd3_000_000_000,
  parameter logic [1:0]  KEYS_NEEDED = 2'd3
) (
  input  logic          clk,
  input  logic          rst,
  ui_flow_ctrl_if.slave bus
);

  ui_state_e     state_q, state_d;
  ui_state_e     last_stage_q, last_stage_d;
  ui_todo_e      todo_q, todo_d;
  logic [1:0]    key_find_q, key_find_d;
  logic [1:0]    heart_q, heart_d;
  logic [1:0]    unlock_q, unlock_d;
  logic          click_dly_q, click_dly_d;
`ifdef STAGE_TIMER_EN
  logic [31:0]   timer_q, timer_d;
`else
  logic          unused_stage_time;
  assign unused_stage_time = ^STAGE_TIME;
`endif

  logic [NUM_BTNS-1:0] btn_hit;
  logic                click_ev;
  logic                enter;
  ui_state_e           enter_st;
  logic                fatal;
  logic [1:0]          kf_next;
  logic                unused_lsb;

  assign unused_lsb = bus.mouse_x[0] ^ bus.mouse_y[0];
  assign click_ev   = bus.mouse_click & ~click_dly_q;

  ui_hit_test u_hit (
    .x       (bus.mouse_x[9:1]),
    .y       (bus.mouse_y[9:1]),
    .btn_hit (btn_hit)
  );

  always_comb begin
    state_d      = state_q;
    last_stage_d = last_stage_q;
    todo_d       = todo_q;
    key_find_d   = key_find_q;
    heart_d      = heart_q;
    unlock_d     = unlock_q;
    click_dly_d  = bus.mouse_click;
    enter        = 1'b0;
    enter_st     = ST_STAGE1;
    fatal        = 1'b0;
    kf_next      = (key_find_q >= KEYS_NEEDED) ? KEYS_NEEDED : key_find_q + 2'd1;
`ifdef STAGE_TIMER_EN
    timer_d      = timer_q;
`endif

    case (state_q)
      ST_TITLE: if (click_ev) begin
        if (btn_hit[BTN_S1]) begin
          enter = 1'b1; enter_st = ST_STAGE1;
        end else if (btn_hit[BTN_S2] && unlock_q[0]) begin
          enter = 1'b1; enter_st = ST_STAGE2;
        end else if (btn_hit[BTN_S3] && unlock_q[1]) begin
          enter = 1'b1; enter_st = ST_STAGE3;
        end else if (btn_hit[BTN_STAFF]) begin
          state_d = ST_STAFF; todo_d = TODO_NONE;
        end
      end
      ST_STAFF: if (click_ev) begin
        state_d = ST_TITLE; todo_d = TODO_NONE;
      end
      ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
`ifdef STAGE_TIMER_EN
        timer_d = timer_q + 32'd1;
`endif
        if (bus.door_pulse && todo_q == TODO_FIND_DOOR) begin
          todo_d = TODO_NONE;
          case (state_q)
            ST_STAGE1: begin state_d = ST_SUCCESS1; unlock_d[0] = 1'b1; end
            ST_STAGE2: begin state_d = ST_SUCCESS2; unlock_d[1] = 1'b1; end
            default:   state_d = ST_SUCCESS3;
          endcase
        end else begin
          if (bus.hit_pulse) begin
            if (heart_q == 2'd1) fatal = 1'b1;
            else heart_d = heart_q - 2'd1;
          end
`ifdef STAGE_TIMER_EN
          if (timer_q == STAGE_TIME - 32'd1) fatal = 1'b1;
`endif
          // A fatal cycle discards any key picked up alongside it.
          if (fatal) begin
            state_d = ST_FAIL; heart_d = 2'd0; todo_d = TODO_NONE;
          end else if (bus.key_pulse) begin
            key_find_d = kf_next;
            if (kf_next == KEYS_NEEDED) todo_d = TODO_FIND_DOOR;
          end
        end
      end
      ST_SUCCESS1, ST_SUCCESS2: if (click_ev) begin
        if (btn_hit[BTN_NEXT]) begin
          enter = 1'b1; enter_st = (state_q == ST_SUCCESS1) ? ST_STAGE2 : ST_STAGE3;
        end else if (btn_hit[BTN_BACK]) begin
          state_d = ST_TITLE; todo_d = TODO_NONE;
        end
      end
      ST_SUCCESS3: if (click_ev) begin
        if (btn_hit[BTN_BACK]) begin
          state_d = ST_TITLE; todo_d = TODO_NONE;
        end else if (btn_hit[BTN_NEXT]) begin
          state_d = ST_STAFF; todo_d = TODO_NONE;
        end
      end
      ST_FAIL: if (click_ev) begin
        if (btn_hit[BTN_RETRY]) begin
          enter = 1'b1; enter_st = last_stage_q;
        end else if (btn_hit[BTN_BACK]) begin
          state_d = ST_TITLE; todo_d = TODO_NONE;
        end
      end
      default: begin
        state_d = ST_TITLE; todo_d = TODO_NONE;
      end
    endcase

    if (enter) begin
      state_d      = enter_st;
      last_stage_d = enter_st;
      key_find_d   = 2'd0;
      heart_d      = 2'd3;
      todo_d       = TODO_FIND_KEY;
`ifdef STAGE_TIMER_EN
      timer_d      = 32'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_TITLE;
      last_stage_q <= ST_STAGE1;
      todo_q       <= TODO_NONE;
      key_find_q   <= 2'd0;
      heart_q      <= 2'd3;
      unlock_q     <= 2'b00;
      click_dly_q  <= 1'b0;
`ifdef STAGE_TIMER_EN
      timer_q      <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      last_stage_q <= last_stage_d;
      todo_q       <= todo_d;
      key_find_q   <= key_find_d;
      heart_q      <= heart_d;
      unlock_q     <= unlock_d;
      click_dly_q  <= click_dly_d;
`ifdef STAGE_TIMER_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign bus.state      = state_q;
  assign bus.key_find   = key_find_q;
  assign bus.heart      = heart_q;
  assign bus.todo       = todo_q;
  assign bus.play_valid = {unlock_q, 2'b10};

endmodule
